// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: encodings, operand struct, accumulator FSM states
// and a leading-zero counter for the 14-bit working significand.
package fp16_pkg;

    localparam logic [15:0] FP16_QNAN   = 16'h7FFF;
    localparam logic [15:0] FP16_PINF   = 16'h7C00;
    localparam logic [15:0] FP16_NZERO  = 16'h8000;
    localparam logic [15:0] FP16_MAXF   = 16'h7BFF;
    localparam int          FP16_BIAS   = 15;
    localparam int          FP16_EXP_W  = 5;
    localparam int          FP16_FRAC_W = 10;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_OUT
    } acc_state_e;

    // Leading zeros of a 14-bit value; 14 when the value is zero.
    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        n = 4'd14;
        for (int i = 0; i < 14; i++)
            if (v[i]) n = 4'(13 - i);
        return n;
    endfunction

endpackage

// File: rtl/fp16_align_shift.sv
// Right-aligns an 11-bit significand into {sig, G, R, S}; every bit shifted
// past S is OR-ed into S. Shifts of 14 or more leave only the sticky bit.
module fp16_align_shift (
    input  logic [10:0] sig,
    input  logic [4:0]  shamt,
    output logic [13:0] sig_out
);

    logic [13:0] ext;
    logic [13:0] shifted;
    logic [13:0] mask;

    // Shift with sticky collection of the dropped bits.
    always_comb begin
        ext     = {sig, 3'b000};
        shifted = ext >> shamt;
        mask    = (14'd1 << shamt) - 14'd1;
        if (shamt >= 5'd14)
            sig_out = {13'd0, |sig};
        else
            sig_out = {shifted[13:1], shifted[0] | (|(ext & mask))};
    end

endmodule

// File: rtl/fp16_accumulator.sv
// FP16 group accumulator: each element takes ALIGN, ADD and NORM/ROUND
// cycles (RNE, subnormals, sticky NaN). A group ends on in_last and the sum
// is held on out_data until out_ready.
// Build option FP16_ACC_SAT_EN: finite overflow saturates to max finite
// instead of producing Inf.
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

`ifdef FP16_ACC_SAT_EN
    localparam logic [14:0] OVF_MAG = FP16_MAXF[14:0];
`else
    localparam logic [14:0] OVF_MAG = FP16_PINF[14:0];
`endif

    acc_state_e       state;
    logic [15:0]      acc;
    fp16_t            in_reg;
    logic             last_r;
    logic [CNT_W-1:0] count;

    // ALIGN -> ADD registers
    logic             al_sign, al_sub, spec_en;
    logic [15:0]      spec_val;
    logic [4:0]       al_exp;
    logic [13:0]      al_a, al_b;
    // ADD -> NORM register
    logic [14:0]      sum;

    assign in_ready = (state == S_ACCEPT);

    // ALIGN: order operands by magnitude and classify specials.
    fp16_t       op_x, op_y, op_a, op_b;
    logic [4:0]  exp_a_eff, exp_b_eff, shamt;
    logic [13:0] b_aligned;
    logic        x_nan, y_nan, x_inf, y_inf;
    logic        sp_en;
    logic [15:0] sp_val;

    always_comb begin
        op_x = acc;
        op_y = in_reg;
        if ({op_y.exp, op_y.frac} > {op_x.exp, op_x.frac}) begin
            op_a = op_y;
            op_b = op_x;
        end else begin
            op_a = op_x;
            op_b = op_y;
        end
        exp_a_eff = (op_a.exp == 5'd0) ? 5'd1 : op_a.exp;
        exp_b_eff = (op_b.exp == 5'd0) ? 5'd1 : op_b.exp;
        shamt     = exp_a_eff - exp_b_eff;

        x_nan  = (&op_x.exp) && (|op_x.frac);
        y_nan  = (&op_y.exp) && (|op_y.frac);
        x_inf  = (&op_x.exp) && !(|op_x.frac);
        y_inf  = (&op_y.exp) && !(|op_y.frac);
        sp_en  = 1'b1;
        sp_val = FP16_QNAN;
        if (x_nan || y_nan)
            sp_val = FP16_QNAN;
        else if (x_inf && y_inf)
            sp_val = (op_x.sign != op_y.sign) ? FP16_QNAN : acc;
        else if (x_inf)
            sp_val = acc;
        else if (y_inf)
            sp_val = in_reg;
        else
            sp_en = 1'b0;
    end

    fp16_align_shift u_align (
        .sig     ({op_b.exp != 5'd0, op_b.frac}),
        .shamt   (shamt),
        .sig_out (b_aligned)
    );

    // NORM/ROUND: normalise the raw sum, round to nearest even, encode.
    logic [3:0]  lz;
    logic [4:0]  lshift;
    logic [13:0] n_sig;
    logic [5:0]  n_exp, e_fin;
    logic        inc;
    logic [11:0] m;
    logic [15:0] norm_res;

    always_comb begin
        lz     = lzc14(sum[13:0]);
        lshift = 5'd0;
        if (sum[14]) begin
            n_sig = {sum[14:2], sum[1] | sum[0]};
            n_exp = {1'b0, al_exp} + 6'd1;
        end else begin
            // Stop at exp 1 so results below the normal range stay subnormal.
            lshift = ({1'b0, lz} < (al_exp - 5'd1)) ? {1'b0, lz} : (al_exp - 5'd1);
            n_sig  = sum[13:0] << lshift;
            n_exp  = {1'b0, al_exp} - {1'b0, lshift};
        end
        inc = n_sig[2] & (n_sig[1] | n_sig[0] | n_sig[3]);
        m   = {1'b0, n_sig[13:3]} + {11'd0, inc};
        if (m[11])
            e_fin = n_exp + 6'd1;
        else if (m[10])
            e_fin = n_exp;
        else
            e_fin = 6'd0;

        if (spec_en)
            norm_res = spec_val;
        else if (al_sub && (sum == 15'd0))
            norm_res = 16'h0000;
        else if (e_fin >= 6'(2 * FP16_BIAS + 1))
            norm_res = {al_sign, OVF_MAG};
        else
            norm_res = {al_sign, e_fin[4:0], m[11] ? m[10:1] : m[9:0]};
    end

    // Control FSM plus the per-stage datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_ACCEPT;
            acc       <= FP16_NZERO;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_count <= '0;
            count     <= '0;
            in_reg    <= '0;
            last_r    <= 1'b0;
            al_sign   <= 1'b0;
            al_sub    <= 1'b0;
            spec_en   <= 1'b0;
            spec_val  <= 16'h0000;
            al_exp    <= 5'd1;
            al_a      <= '0;
            al_b      <= '0;
            sum       <= '0;
        end else begin
            case (state)
                S_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        in_reg <= in_data;
                        last_r <= in_last;
                        if (count != '1) count <= count + 1'b1;
                        state  <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    al_sign  <= op_a.sign;
                    al_sub   <= op_a.sign ^ op_b.sign;
                    al_exp   <= exp_a_eff;
                    al_a     <= {op_a.exp != 5'd0, op_a.frac, 3'b000};
                    al_b     <= b_aligned;
                    spec_en  <= sp_en;
                    spec_val <= sp_val;
                    state    <= S_ADD;
                end
                S_ADD: begin
                    sum   <= al_sub ? ({1'b0, al_a} - {1'b0, al_b})
                                    : ({1'b0, al_a} + {1'b0, al_b});
                    state <= S_NORM;
                end
                S_NORM: begin
                    acc <= norm_res;
                    if (last_r) begin
                        out_valid <= 1'b1;
                        out_data  <= norm_res;
                        out_count <= count;
                        state     <= S_OUT;
                    end else begin
                        state <= S_ACCEPT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc       <= FP16_NZERO;
                        count     <= '0;
                        out_valid <= 1'b0;
                        state     <= S_ACCEPT;
                    end
                end
                default: state <= S_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Bench for fp16_accumulator: directed groups from the plan plus random
// groups checked against a real-arithmetic FP16 model.
module tb_fp16_accumulator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] grp[$];

    fp16_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

`ifdef FP16_ACC_SAT_EN
    localparam logic [14:0] OVF = 15'h7BFF;
`else
    localparam logic [14:0] OVF = 15'h7C00;
`endif

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [15:0] h);
        real m;
        int  e = int'(h[14:10]);
        int  f = int'(h[9:0]);
        if (e == 0) m = f * pow2(-24);
        else        m = (1024 + f) * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    function automatic int bin_exp(input real ax);
        int e = -14;
        while (e < 15 && pow2(e + 1) <= ax) e++;
        return e;
    endfunction

    function automatic logic [15:0] r2f(input real x);
        logic s = (x < 0.0);
        real  ax = s ? -x : x;
        real  q, fl, fr, v;
        int   e, fi;
        e  = bin_exp(ax);
        q  = ax / pow2(e - 10);
        fl = $floor(q);
        fr = q - fl;
        if (fr > 0.5 || (fr == 0.5 && ($rtoi(fl) % 2) == 1)) fl = fl + 1.0;
        v = fl * pow2(e - 10);
        if (v >= 65536.0) return {s, OVF};
        if (v < pow2(-14)) begin
            fi = $rtoi(v / pow2(-24));
            return {s, 5'd0, 10'(fi)};
        end
        e  = bin_exp(v);
        fi = $rtoi(v / pow2(e - 10)) - 1024;
        return {s, 5'(e + 15), 10'(fi)};
    endfunction

    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        logic a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        logic b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        logic a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        logic b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        real  x;
        if (a_nan || b_nan) return 16'h7FFF;
        if (a_inf && b_inf) return (a[15] != b[15]) ? 16'h7FFF : a;
        if (a_inf) return a;
        if (b_inf) return b;
        x = f2r(a) + f2r(b);
        if (x == 0.0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
        return r2f(x);
    endfunction

    function automatic logic [15:0] model_group();
        logic [15:0] s = 16'h8000;
        foreach (grp[i]) s = model_add(s, grp[i]);
        return s;
    endfunction

    function automatic logic [15:0] rand_fp16();
        int k = int'($urandom_range(0, 9));
        if (k < 5)      return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
        else if (k < 7) return {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
        else if (k < 9) return 16'($urandom);
        else            return {1'($urandom), 5'd30, 10'($urandom)};
    endfunction

    // ---------------- drivers ----------------
    // Sends grp; lat = edges from the last handshake to out_valid.
    task automatic send_group(output int lat);
        for (int i = 0; i < grp.size(); i++) begin
            int g = 0;
            while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
            in_valid = 1'b1;
            in_data  = grp[i];
            in_last  = (i == grp.size() - 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL out_valid_timeout: got 0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (in_ready !== 1'b1)   begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_data !== 16'h0)  begin bad++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
        if (out_count !== 8'h0)  begin bad++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        grp = '{16'h3C00, 16'h4000};
        send_group(lat);
        total += 3;
        if (out_data !== 16'h4200) begin bad++; $display("FAIL basic_data: got %h want 4200", out_data); end
        if (out_count !== 8'd2)    begin bad++; $display("FAIL basic_count: got %0d want 2", out_count); end
        if (lat != 3)              begin bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
        accept_result();
    endtask

    task automatic test_directed();
        logic [15:0] g0[$], want;
        int lat;
        logic [15:0] cases[9][3];
        logic [15:0] wants[9];
        int          lens[9];
        cases = '{'{16'h3C00, 16'h1000, 0}, '{16'h3C01, 16'h1000, 0},
                  '{16'h3C00, 16'hBC00, 0}, '{16'h8000, 0, 0},
                  '{16'h0001, 16'h0001, 0}, '{16'h7C00, 16'hFC00, 0},
                  '{16'h7E00, 16'h3C00, 0}, '{16'h7BFF, 16'h7BFF, 0},
                  '{16'h7E00, 16'h3C00, 16'hFC00}};
        lens  = '{2, 2, 2, 1, 2, 2, 2, 2, 3};
        wants = '{16'h3C00, 16'h3C02, 16'h0000, 16'h8000, 16'h0002,
                  16'h7FFF, 16'h7FFF, {1'b0, OVF}, 16'h7FFF};
        for (int c = 0; c < 9; c++) begin
            grp = {};
            for (int i = 0; i < lens[c]; i++) grp.push_back(cases[c][i]);
            want = wants[c];
            send_group(lat);
            total++;
            if (out_data !== want) begin
                bad++; $display("FAIL directed_%0d: got %h want %h", c, out_data, want);
            end
            accept_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        grp = '{16'h3C00, 16'h3C00};
        send_group(lat);
        for (int i = 0; i < 5; i++) begin
            total += 3;
            if (out_valid !== 1'b1)   begin bad++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
            if (out_data !== 16'h4000) begin bad++; $display("FAIL bp_data_%0d: got %h want 4000", i, out_data); end
            if (in_ready !== 1'b0)    begin bad++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        accept_result();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        grp = '{16'h4000};
        send_group(lat);
        total += 2;
        if (out_data !== 16'h4000) begin bad++; $display("FAIL bp_next_data: got %h want 4000", out_data); end
        if (out_count !== 8'd1)    begin bad++; $display("FAIL bp_next_count: got %0d want 1", out_count); end
        accept_result();
    endtask

    task automatic test_reset_mid();
        int lat;
        int g = 0;
        // first element completes so the partial sum is non-trivial
        in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!in_ready && g < 20) begin @(posedge clk); #1; g++; end
        in_valid = 1'b1; in_data = 16'h4000;
        @(posedge clk); #1;          // handshake -> ALIGN
        in_valid = 1'b0;
        @(posedge clk); #1;          // -> ADD
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        total += 2;
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        grp = '{16'h3C00};
        send_group(lat);
        total += 2;
        if (out_data !== 16'h3C00) begin bad++; $display("FAIL midrst_data: got %h want 3C00", out_data); end
        if (out_count !== 8'd1)    begin bad++; $display("FAIL midrst_count: got %0d want 1", out_count); end
        accept_result();
    endtask

    task automatic test_count_sat();
        int lat;
        logic [15:0] want;
        grp = {};
        for (int i = 0; i < 260; i++) grp.push_back(16'h3C00);
        want = model_group();
        send_group(lat);
        total += 2;
        if (out_count !== 8'd255) begin bad++; $display("FAIL sat_count: got %0d want 255", out_count); end
        if (out_data !== want)    begin bad++; $display("FAIL sat_data: got %h want %h", out_data, want); end
        accept_result();
    endtask

    task automatic test_random();
        int lat, n;
        logic [15:0] want;
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(1, 6));
            grp = {};
            for (int i = 0; i < n; i++) grp.push_back(rand_fp16());
            want = model_group();
            send_group(lat);
            total += 2;
            if (out_data !== want) begin
                bad++; $display("FAIL rand_%0d_data: got %h want %h (n=%0d first=%h)", t, out_data, want, n, grp[0]);
            end
            if (out_count !== 8'(n)) begin
                bad++; $display("FAIL rand_%0d_count: got %0d want %0d", t, out_count, n);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            accept_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_count_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
